// File: rtl/systolic_array_is_ctrl.sv
// rtl/systolic_array_is_ctrl.sv - input-stationary systolic array sequencer
// Runs LOAD -> STREAM (weights, drain, results) -> FIN for one tile per start.
module systolic_array_is_ctrl #(
  parameter int ARRAY_HEIGHT  = 4,
  parameter int ARRAY_WIDTH   = 4,
  parameter int OUT_LATENCY   = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int VEC_CNT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [VEC_CNT_WIDTH-1:0] cfg_num_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     input_en,
  output logic                     process_en,
  output logic [ADDR_WIDTH-1:0]    in_rd_addr,
  output logic                     wt_rd_en,
  output logic [ADDR_WIDTH-1:0]    wt_rd_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_addr
);

  // t must hold OUT_LATENCY + max(N) without wrapping
  localparam int T_NEED = $clog2(OUT_LATENCY + (2 ** VEC_CNT_WIDTH));
  localparam int T_W    = (T_NEED > VEC_CNT_WIDTH + 1) ? T_NEED : VEC_CNT_WIDTH + 1;
  localparam int LC_W   = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} state_t;

  state_t                   state, state_next;
  logic [VEC_CNT_WIDTH-1:0] num_vec;
  logic [LC_W-1:0]          load_cnt;
  logic [T_W-1:0]           t;
  logic [T_W-1:0]           n_ext;
  logic [T_W-1:0]           res_end;
  logic                     last_load;

  assign n_ext     = T_W'(num_vec);
  assign res_end   = n_ext + T_W'(OUT_LATENCY);
  assign last_load = (load_cnt == LC_W'(ARRAY_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num_vec  <= '0;
      load_cnt <= '0;
      t        <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            num_vec  <= cfg_num_vec;
            load_cnt <= '0;
            t        <= '0;
          end
        end
        LOAD: begin
          load_cnt <= last_load ? '0 : load_cnt + 1'b1;
          t        <= '0;
        end
        STREAM: begin
          if (process_en) t <= t + 1'b1;
        end
        default: begin
          load_cnt <= '0;
          t        <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    input_en   = 1'b0;
    process_en = 1'b0;
    in_rd_addr = '0;
    wt_rd_en   = 1'b0;
    wt_rd_addr = '0;
    out_valid  = 1'b0;
    out_addr   = '0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        input_en   = 1'b1;
        in_rd_addr = ADDR_WIDTH'(load_cnt);
        if (last_load) state_next = (num_vec != '0) ? STREAM : FIN;
      end
      STREAM: begin
        busy       = 1'b1;
        wt_rd_en   = (t < n_ext);
        // Past the last weight the address parks on N-1; weights are zeroed by wt_rd_en
        wt_rd_addr = wt_rd_en ? ADDR_WIDTH'(t) : ADDR_WIDTH'(n_ext - 1'b1);
        out_valid  = (t >= T_W'(OUT_LATENCY)) && (t < res_end);
        out_addr   = out_valid ? ADDR_WIDTH'(t - T_W'(OUT_LATENCY)) : '0;
        process_en = !(out_valid && !out_ready);
        if (out_valid && out_ready && (t == res_end - 1'b1)) state_next = FIN;
      end
      default: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_array_is_ctrl.sv
// tb/tb_systolic_array_is_ctrl.sv - directed bench for systolic_array_is_ctrl
// Drives tiles cycle by cycle at negedge and checks against hand-computed counts.
module tb_systolic_array_is_ctrl;
  localparam int AH  = 4;
  localparam int AWC = 4;
  localparam int OL  = 8;
  localparam int VW  = 8;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] cfg_num_vec;
  logic          busy, done, input_en, process_en, wt_rd_en, out_valid, out_ready;
  logic [AW-1:0] in_rd_addr, wt_rd_addr, out_addr;

  systolic_array_is_ctrl #(
    .ARRAY_HEIGHT(AH), .ARRAY_WIDTH(AWC), .OUT_LATENCY(OL),
    .VEC_CNT_WIDTH(VW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_vec(cfg_num_vec),
    .busy(busy), .done(done), .input_en(input_en), .process_en(process_en),
    .in_rd_addr(in_rd_addr), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int n_in, n_wt, n_valid, n_acc, n_proc, n_done, done_cyc, first_valid_proc;
  int n_overlap, n_stall, seq_err, proto_err, hold_addr, rst_wt_addr, rst_outs;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs_nonzero();
    return int'(busy | done | input_en | process_en | wt_rd_en | out_valid |
                 (|in_rd_addr) | (|wt_rd_addr) | (|out_addr));
  endfunction

  // mode 0: out_ready always 1; mode 1: ready follows 0,1,0,0,1 over valid cycles
  task automatic run_tile(input int n, input int mode, input logic [31:0] poke,
                          input int rst_cyc);
    int in_idx, wt_idx, acc_idx, vcount;
    bit seen_wt, seen_valid, prev_stall;
    logic [AW-1:0] prev_addr;
    logic [4:0] pat;
    pat = 5'b10010;
    n_in = 0; n_wt = 0; n_valid = 0; n_acc = 0; n_proc = 0; n_done = 0;
    done_cyc = -1; first_valid_proc = 0; n_overlap = 0; n_stall = 0;
    seq_err = 0; proto_err = 0; hold_addr = -1; rst_wt_addr = -1; rst_outs = -1;
    in_idx = 0; wt_idx = 0; acc_idx = 0; vcount = 0;
    seen_wt = 0; seen_valid = 0; prev_stall = 0; prev_addr = '0;
    @(negedge clk);
    start = 1'b1;
    cfg_num_vec = VW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_num_vec = 8'd7;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = (cyc < 32) ? poke[cyc] : 1'b0;
      out_ready = (mode == 0) ? 1'b1 : pat[vcount % 5];
      if (cyc == rst_cyc) rst = 1'b1;
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        rst = 1'b0;
        #1;
        rst_outs = outs_nonzero();
        return;
      end
      #1;
      if (cyc == rst_cyc) rst_wt_addr = int'(wt_rd_addr);
      if (input_en) begin
        if (int'(in_rd_addr) != in_idx) seq_err++;
        in_idx++;
        n_in++;
      end
      if (input_en && process_en) proto_err++;
      if (busy && !input_en && !done && (process_en !== !(out_valid && !out_ready))) proto_err++;
      if (prev_stall && (!out_valid || out_addr != prev_addr)) proto_err++;
      if (process_en) n_proc++;
      if (wt_rd_en && !seen_wt) seen_wt = 1;
      if (seen_wt && !seen_valid && !out_valid && process_en) first_valid_proc++;
      if (wt_rd_en && process_en) begin
        if (int'(wt_rd_addr) != wt_idx) seq_err++;
        wt_idx++;
        n_wt++;
      end
      if (out_valid && !wt_rd_en) hold_addr = int'(wt_rd_addr);
      if (out_valid) begin
        seen_valid = 1;
        n_valid++;
        vcount++;
        if (wt_rd_en) n_overlap++;
        if (!out_ready) n_stall++;
        else begin
          if (int'(out_addr) != acc_idx) seq_err++;
          acc_idx++;
          n_acc++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_addr = out_addr;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0 && rst_cyc == 0) check("timeout_done", 0, 1);
  endtask

  task automatic idle_busy(input string tag);
    @(negedge clk);
    start = 1'b0;
    #1;
    check(tag, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_num_vec = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_nonzero(), 0);
    rst = 1'b0;

    run_tile(3, 0, 32'h0, 0);
    check("basic_in_cycles", n_in, AH);
    check("basic_wt_cycles", n_wt, 3);
    check("basic_valid_cycles", n_valid, 3);
    check("basic_accepts", n_acc, 3);
    check("basic_latency", first_valid_proc, OL);
    check("basic_wt_hold_addr", hold_addr, 2);
    check("basic_done_cycle", done_cyc, 16);
    check("basic_seq_err", seq_err, 0);
    check("basic_proto_err", proto_err, 0);
    idle_busy("basic_idle_after");
    check("basic_single_done", int'(done), 0);

    run_tile(4, 1, 32'h0, 0);
    check("bp_accepts", n_acc, 4);
    check("bp_stalls", n_stall, 6);
    check("bp_valid_cycles", n_valid, 10);
    check("bp_proc_cycles", n_proc, 12);
    check("bp_done_cycle", done_cyc, 23);
    check("bp_seq_err", seq_err, 0);
    check("bp_proto_err", proto_err, 0);

    run_tile(0, 0, 32'h0, 0);
    check("n0_in_cycles", n_in, AH);
    check("n0_done_cycle", done_cyc, 5);
    check("n0_proc_cycles", n_proc, 0);
    check("n0_wt_cycles", n_wt, 0);
    check("n0_valid_cycles", n_valid, 0);

    run_tile(20, 0, 32'h0, 0);
    check("long_overlap", n_overlap, 12);
    check("long_wt_cycles", n_wt, 20);
    check("long_accepts", n_acc, 20);
    check("long_done_cycle", done_cyc, 33);
    check("long_seq_err", seq_err, 0);
    check("long_proto_err", proto_err, 0);

    run_tile(10, 0, 32'h0, 10);
    check("rst_at_t5", rst_wt_addr, 5);
    check("rst_outputs_zero", rst_outs, 0);
    run_tile(2, 0, 32'h0, 0);
    check("post_rst_done_cycle", done_cyc, 15);
    check("post_rst_accepts", n_acc, 2);
    check("post_rst_seq_err", seq_err, 0);

    run_tile(3, 0, (32'h1 << 2) | (32'h1 << 7) | (32'h1 << 16), 0);
    check("poke_done_cycle", done_cyc, 16);
    check("poke_wt_cycles", n_wt, 3);
    check("poke_accepts", n_acc, 3);
    idle_busy("poke_fin_ignored");
    idle_busy("poke_still_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
